fp_add_sched: RTL and testbench

- Schedules and shares one pipelined IEEE-754 single-precision adder (fixed latency, clocked, no handshake of its own) between NREQ requesters.
- Requesters present operand pairs with valid/ready. A round-robin arbiter issues at most one pair per cycle to the adder. A tag pipeline routes each sum back to its originator.
- A halt/drain FSM quiesces the adder so it can be reconfigured or swapped.
- Sits between the compute clients and the shared adder instance.

---
 rtl/fp_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/fp_add_sched.sv | 126 ++++++++++++
 tb/tb_fp_add_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// Shared types for the fp adder scheduler: operand type, FSM states and the
// routing tag that travels alongside each operation through the adder.
package fp_sched_pkg;

    localparam int unsigned FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} sched_state_t;

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
    } sched_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting the search just
// after the last granted requester, plus the pointer register.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [2:0]    ptr_q;
    logic          found;
    int unsigned   c;
    logic [IW-1:0] ci;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = 0;
        ci      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            c = 32'(ptr_q) + i;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            ci = IW'(c);
            if (!found && req[ci]) begin
                found   = 1'b1;
                gnt[ci] = 1'b1;
                gnt_idx = 3'(c);
            end
        end
    end

    // Reset to the last index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 3'(NREQ - 1);
        end else if (|gnt) begin
            ptr_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// Shares one fixed-latency pipelined fp adder between NREQ requesters, routing
// each sum back via a tag pipeline, with a halt/drain FSM to quiesce the adder.
module fp_add_sched
    import fp_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned LAT  = 3,
    parameter int unsigned W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][W-1:0]     req_a,
    input  logic [NREQ-1:0][W-1:0]     req_b,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            resp_valid,
    output logic [W-1:0]               resp_data,
    output logic [W-1:0]               add_a,
    output logic [W-1:0]               add_b,
    input  logic [W-1:0]               add_res,
    input  logic                       halt_req,
    output logic                       halted,
    output logic [$clog2(LAT+1)-1:0]   inflight
);

    localparam int unsigned CW = $clog2(LAT + 1);

    sched_state_t    state_q, state_d;
    sched_tag_t      tag_q [LAT];
    logic [CW-1:0]   cnt_q;
    logic            issue_en;
    logic            issue;
    logic            retire;
    logic [NREQ-1:0] gnt;
    logic [2:0]      gnt_idx;

    // Gating on rst keeps grants and adder operands at zero while reset is held.
    assign issue_en = (state_q == RUN) && !halt_req && !rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid & {NREQ{issue_en}}),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign issue     = |gnt;
    assign retire    = tag_q[LAT-1].v;
    assign halted    = (state_q == HALTED);
    assign inflight  = cnt_q;
    assign resp_data = retire ? add_res : '0;

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                add_a = req_a[i];
                add_b = req_b[i];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i] = retire && (tag_q[LAT-1].idx == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{v: issue, idx: gnt_idx};
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (issue && !retire) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (retire && !issue) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!halt_req) begin
                    state_d = RUN;
                end else if (cnt_q == '0 || (cnt_q == CW'(1) && retire)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed bench for fp_add_sched with a 3-cycle stand-in adder that returns
// hand-computed IEEE sums for the operand pairs used here.
module tb_fp_add_sched;

    localparam int NREQ = 2;
    localparam int LAT  = 3;
    localparam int W    = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0][W-1:0] req_a;
    logic [NREQ-1:0][W-1:0] req_b;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        resp_valid;
    logic [W-1:0]           resp_data;
    logic [W-1:0]           add_a;
    logic [W-1:0]           add_b;
    logic [W-1:0]           add_res;
    logic                   halt_req;
    logic                   halted;
    logic [1:0]             inflight;

    logic [W-1:0] p0 = '0;
    logic [W-1:0] p1 = '0;
    logic [W-1:0] p2 = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_add_sched #(
        .NREQ (NREQ),
        .LAT  (LAT),
        .W    (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_res    (add_res),
        .halt_req   (halt_req),
        .halted     (halted),
        .inflight   (inflight)
    );

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            64'h3F800000_40000000: return 32'h40400000;  // 1.0 + 2.0
            64'h3F800000_3F800000: return 32'h40000000;  // 1.0 + 1.0
            64'h40000000_40000000: return 32'h40800000;  // 2.0 + 2.0
            64'h3F000000_3F000000: return 32'h3F800000;  // 0.5 + 0.5
            64'h7F800000_00000000: return 32'h7F800000;  // inf + 0
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        p0 <= fadd(add_a, add_b);
        p1 <= p0;
        p2 <= p1;
    end
    assign add_res = p2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    initial begin
        rst       = 1'b1;
        halt_req  = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_valid = 2'b11;
        #2;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_inflight", 32'(inflight), 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        next_cyc();
        rst       = 1'b0;
        req_valid = 2'b00;

        // Contention: both requesters valid for 6 cycles.
        req_a[0] = 32'h3F800000; req_b[0] = 32'h3F800000;
        req_a[1] = 32'h40000000; req_b[1] = 32'h40000000;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 6) ? 2'b11 : 2'b00;
            @(negedge clk);
            check("cont_ready", 32'(req_ready), (k < 6) ? ((k % 2 == 0) ? 1 : 2) : 0);
            check("cont_inflight", 32'(inflight),
                  32'(clampi(k, 0, 6) - clampi(k - 3, 0, 6)));
            if (k >= 3 && k <= 8) begin
                check("cont_resp_valid", 32'(resp_valid), ((k - 3) % 2 == 0) ? 1 : 2);
                check("cont_resp_data", resp_data,
                      ((k - 3) % 2 == 0) ? 32'h40000000 : 32'h40800000);
            end else begin
                check("cont_resp_idle", 32'(resp_valid), 0);
            end
            next_cyc();
        end

        // Single issue from requester 0.
        req_a[0] = 32'h3F800000; req_b[0] = 32'h40000000;
        for (int k = 0; k < 5; k++) begin
            req_valid = (k == 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            if (k == 0) begin
                check("single_ready", 32'(req_ready), 1);
                check("single_add_a", add_a, 32'h3F800000);
                check("single_add_b", add_b, 32'h40000000);
            end
            check("single_inflight", 32'(inflight), (k >= 1 && k <= 3) ? 1 : 0);
            check("single_resp_valid", 32'(resp_valid), (k == 3) ? 1 : 0);
            if (k == 3) check("single_resp_data", resp_data, 32'h40400000);
            next_cyc();
        end

        // Back-to-back requester 1 for 4 cycles.
        req_a[1] = 32'h3F000000; req_b[1] = 32'h3F000000;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 4) ? 2'b10 : 2'b00;
            @(negedge clk);
            check("b2b_ready", 32'(req_ready), (k < 4) ? 2 : 0);
            check("b2b_inflight", 32'(inflight),
                  32'(clampi(k, 0, 4) - clampi(k - 3, 0, 4)));
            check("b2b_resp_valid", 32'(resp_valid), (k >= 3 && k <= 6) ? 2 : 0);
            if (k >= 3 && k <= 6) check("b2b_resp_data", resp_data, 32'h3F800000);
            next_cyc();
        end

        // Halt with two operations in flight.
        req_a[0] = 32'h3F800000; req_b[0] = 32'h40000000;
        req_valid = 2'b01;
        @(negedge clk); check("halt_pre_ready0", 32'(req_ready), 1); next_cyc();
        @(negedge clk); check("halt_pre_ready1", 32'(req_ready), 1); next_cyc();
        halt_req = 1'b1;
        @(negedge clk);
        check("halt_ready_drop", 32'(req_ready), 0);
        check("halt_add_a", add_a, 0);
        check("halt_inflight2", 32'(inflight), 2);
        next_cyc();
        @(negedge clk);
        check("drain_resp0", 32'(resp_valid), 1);
        check("drain_inflight2", 32'(inflight), 2);
        check("drain_halted0", 32'(halted), 0);
        check("drain_ready", 32'(req_ready), 0);
        next_cyc();
        @(negedge clk);
        check("drain_resp1", 32'(resp_valid), 1);
        check("drain_inflight1", 32'(inflight), 1);
        check("drain_halted1", 32'(halted), 0);
        next_cyc();
        @(negedge clk);
        check("halted_set", 32'(halted), 1);
        check("halted_inflight", 32'(inflight), 0);
        check("halted_ready", 32'(req_ready), 0);
        check("halted_resp", 32'(resp_valid), 0);
        next_cyc();
        halt_req = 1'b0;
        @(negedge clk);
        check("unhalt_still_halted", 32'(halted), 1);
        check("unhalt_no_grant", 32'(req_ready), 0);
        next_cyc();
        @(negedge clk);
        check("resume_halted", 32'(halted), 0);
        check("resume_grant", 32'(req_ready), 1);
        next_cyc();
        @(negedge clk); check("fill_grant0", 32'(req_ready), 1); next_cyc();
        @(negedge clk); check("fill_grant1", 32'(req_ready), 1); next_cyc();
        req_valid = 2'b00;
        @(negedge clk);
        check("full_inflight", 32'(inflight), 3);
        check("full_resp", 32'(resp_valid), 1);
        check("full_resp_data", resp_data, 32'h40400000);

        // Reset mid-flight.
        #1;
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        check("midrst_ready", 32'(req_ready), 0);
        check("midrst_resp", 32'(resp_valid), 0);
        check("midrst_resp_data", resp_data, 0);
        check("midrst_inflight", 32'(inflight), 0);
        check("midrst_halted", 32'(halted), 0);
        check("midrst_add_a", add_a, 0);
        next_cyc();
        rst       = 1'b0;
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("postrst_resp", 32'(resp_valid), 0);
            check("postrst_inflight", 32'(inflight), 0);
            next_cyc();
        end

        // Special values pass through; first grant after reset goes to requester 0.
        req_a[0] = 32'h7F800000; req_b[0] = 32'h00000000;
        req_a[1] = 32'h40000000; req_b[1] = 32'h40000000;
        req_valid = 2'b11;
        @(negedge clk);
        check("postrst_grant", 32'(req_ready), 1);
        check("inf_add_a", add_a, 32'h7F800000);
        check("inf_add_b", add_b, 32'h00000000);
        next_cyc();
        req_valid = 2'b00;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("inf_resp_valid", 32'(resp_valid), (k == 3) ? 1 : 0);
            if (k == 3) check("inf_resp_data", resp_data, 32'h7F800000);
            next_cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
